// File: rtl/ines_pkg.sv
// ines_pkg: shared states, lengths and magic bytes for the iNES stream loader.
package ines_pkg;
    typedef enum logic [2:0] {HDR, TRAINER, PRG, CHR, DONE, ERR} state_t;
    localparam int HDR_LEN        = 16;
    localparam int TRAINER_LEN    = 512;
    localparam int PRG_BANK_BYTES = 16384;
    localparam int CHR_BANK_BYTES = 8192;
    // Element 0 is the first byte of the file: "NES" followed by 0x1A.
    localparam logic [3:0][7:0] MAGIC = {8'h1A, 8'h53, 8'h45, 8'h4E};
endpackage

// File: rtl/ines_header_decode.sv
// ines_header_decode: latches header bytes 4-7 and derives bank counts, mapper,
// mirroring, trainer presence and whether the image fits the write ports.
module ines_header_decode #(
    parameter int PRG_ADDR_W = 15,
    parameter int CHR_ADDR_W = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [3:0] idx,
    input  logic [7:0] data,
    output logic [7:0] prg_banks,
    output logic [7:0] chr_banks,
    output logic [7:0] mapper,
    output logic       mirror_v,
    output logic       trainer,
    output logic       size_ok
);
    localparam int PRG_MAX = 1 << (PRG_ADDR_W - 14);
    localparam int CHR_MAX = 1 << (CHR_ADDR_W - 13);

    logic [3:0] map_lo, map_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            prg_banks <= 8'd0;
            chr_banks <= 8'd0;
            map_lo    <= 4'd0;
            map_hi    <= 4'd0;
            mirror_v  <= 1'b0;
            trainer   <= 1'b0;
        end else if (wr) begin
            if (idx == 4'd4) prg_banks <= data;
            if (idx == 4'd5) chr_banks <= data;
            if (idx == 4'd6) begin
                map_lo   <= data[7:4];
                trainer  <= data[2];
                mirror_v <= data[0];
            end
            if (idx == 4'd7) map_hi <= data[7:4];
        end
    end

    assign mapper  = {map_hi, map_lo};
    assign size_ok = prg_banks != 8'd0 && 32'(prg_banks) <= PRG_MAX && 32'(chr_banks) <= CHR_MAX;
endmodule

// File: rtl/ines_loader.sv
// ines_loader: consumes an iNES byte stream, checks the header, skips any trainer
// and writes PRG then CHR data to their memories at sequential addresses.
module ines_loader
    import ines_pkg::*;
#(
    parameter int PRG_ADDR_W = 15,
    parameter int CHR_ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  prg_we,
    output logic [PRG_ADDR_W-1:0] prg_addr,
    output logic [7:0]            prg_wdata,
    output logic                  chr_we,
    output logic [CHR_ADDR_W-1:0] chr_addr,
    output logic [7:0]            chr_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            prg_banks,
    output logic [7:0]            chr_banks,
    output logic [7:0]            mapper,
    output logic                  mirror_v
);
    state_t      state;
    logic [15:0] cnt;
    logic        accept, trainer, size_ok, bad_magic, prg_last, chr_last;

    assign s_ready   = !rst && state != DONE && state != ERR;
    assign accept    = s_valid && s_ready;
    assign bad_magic = cnt < 16'd4 && s_data != MAGIC[cnt[1:0]];
    assign prg_last  = 24'(cnt) == 24'(prg_banks) * 24'(PRG_BANK_BYTES) - 24'd1;
    assign chr_last  = 24'(cnt) == 24'(chr_banks) * 24'(CHR_BANK_BYTES) - 24'd1;

    ines_header_decode #(.PRG_ADDR_W(PRG_ADDR_W), .CHR_ADDR_W(CHR_ADDR_W)) u_hdr (
        .clk      (clk),
        .rst      (rst),
        .wr       (accept && state == HDR),
        .idx      (cnt[3:0]),
        .data     (s_data),
        .prg_banks(prg_banks),
        .chr_banks(chr_banks),
        .mapper   (mapper),
        .mirror_v (mirror_v),
        .trainer  (trainer),
        .size_ok  (size_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            cnt       <= 16'd0;
            prg_we    <= 1'b0;
            prg_addr  <= '0;
            prg_wdata <= 8'd0;
            chr_we    <= 1'b0;
            chr_addr  <= '0;
            chr_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            prg_we <= 1'b0;
            chr_we <= 1'b0;
            if (accept) begin
                cnt  <= cnt + 16'd1;
                busy <= 1'b1;
                case (state)
                    HDR: begin
                        if (bad_magic) begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                            cnt   <= 16'd0;
                        end else if (cnt == 16'(HDR_LEN - 1)) begin
                            cnt <= 16'd0;
                            if (!size_ok) begin
                                state <= ERR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= trainer ? TRAINER : PRG;
                            end
                        end
                    end
                    TRAINER: begin
                        if (cnt == 16'(TRAINER_LEN - 1)) begin
                            state <= PRG;
                            cnt   <= 16'd0;
                        end
                    end
                    PRG: begin
                        prg_we    <= 1'b1;
                        prg_addr  <= cnt[PRG_ADDR_W-1:0];
                        prg_wdata <= s_data;
                        if (prg_last) begin
                            // No CHR banks means CHR-RAM: the load ends here.
                            state <= chr_banks != 8'd0 ? CHR : DONE;
                            done  <= chr_banks == 8'd0;
                            busy  <= chr_banks != 8'd0;
                            cnt   <= 16'd0;
                        end
                    end
                    CHR: begin
                        chr_we    <= 1'b1;
                        chr_addr  <= cnt[CHR_ADDR_W-1:0];
                        chr_wdata <= s_data;
                        if (chr_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            cnt   <= 16'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: random iNES images streamed into the loader and checked cycle by
// cycle against a byte-index model of where every accepted byte must land.
module tb_ines_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready, prg_we, chr_we, busy, done, error, mirror_v;
    logic [14:0] prg_addr;
    logic [12:0] chr_addr;
    logic [7:0]  prg_wdata, chr_wdata, prg_banks, chr_banks, mapper;

    always #5 clk = ~clk;

    ines_loader #(.PRG_ADDR_W(15), .CHR_ADDR_W(13)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
        .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
        .busy(busy), .done(done), .error(error), .prg_banks(prg_banks),
        .chr_banks(chr_banks), .mapper(mapper), .mirror_v(mirror_v)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] img[$];
    logic [7:0] prg_mem[32768];
    logic [7:0] chr_mem[8192];
    int k, last_k, end_k, bad_at, t_len, p_len, c_len, prg_cnt, chr_cnt;
    logic last_acc;
    logic [7:0] e_prg, e_chr, e_map;
    logic e_mir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Image model: where it errors (if at all), trainer/PRG/CHR lengths, header outputs.
    task automatic build(input logic [7:0] b4, b5, b6, b7, m2);
        logic size_ok;
        img.delete();
        img.push_back(8'h4E); img.push_back(8'h45); img.push_back(m2); img.push_back(8'h1A);
        img.push_back(b4); img.push_back(b5); img.push_back(b6); img.push_back(b7);
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
        size_ok = b4 != 0 && b4 <= 2 && b5 <= 1;
        bad_at  = m2 != 8'h53 ? 2 : !size_ok ? 15 : -1;
        t_len   = (bad_at < 0 && b6[2]) ? 512 : 0;
        p_len   = bad_at < 0 ? int'(b4) * 16384 : 0;
        c_len   = bad_at < 0 ? int'(b5) * 8192 : 0;
        for (int i = 0; i < t_len + p_len + c_len + 40; i++) img.push_back(8'($urandom));
        end_k = bad_at < 0 ? 16 + t_len + p_len + c_len : bad_at + 1;
        e_prg = (bad_at < 0 || bad_at >= 8) ? b4 : 8'd0;
        e_chr = (bad_at < 0 || bad_at >= 8) ? b5 : 8'd0;
        e_map = (bad_at < 0 || bad_at >= 8) ? {b7[7:4], b6[7:4]} : 8'd0;
        e_mir = (bad_at < 0 || bad_at >= 8) ? b6[0] : 1'b0;
    endtask

    task automatic cyc(input logic v);
        logic acc, is_prg, is_chr;
        int pos;
        s_valid = v;
        s_data  = (v && k < img.size()) ? img[k] : 8'($urandom);
        acc = v && k < end_k;
        @(posedge clk);
        last_acc = acc;
        if (acc) begin
            last_k = k;
            k++;
        end
        @(negedge clk);
        pos    = last_k - 16 - t_len;
        is_prg = last_acc && bad_at < 0 && pos >= 0 && pos < p_len;
        is_chr = last_acc && bad_at < 0 && pos >= p_len && pos < p_len + c_len;
        chk("s_ready", 32'(s_ready), 32'(k < end_k));
        chk("prg_we", 32'(prg_we), 32'(is_prg));
        if (is_prg) begin
            chk("prg_addr", 32'(prg_addr), pos);
            chk("prg_wdata", 32'(prg_wdata), 32'(img[last_k]));
        end
        chk("chr_we", 32'(chr_we), 32'(is_chr));
        if (is_chr) begin
            chk("chr_addr", 32'(chr_addr), pos - p_len);
            chk("chr_wdata", 32'(chr_wdata), 32'(img[last_k]));
        end
        chk("done", 32'(done), 32'(bad_at < 0 && k == end_k));
        chk("error", 32'(error), 32'(bad_at >= 0 && k == end_k));
        chk("busy", 32'(busy), 32'(k > 0 && k < end_k));
        if (prg_we) begin
            prg_mem[prg_addr] = prg_wdata;
            prg_cnt++;
        end
        if (chr_we) begin
            chr_mem[chr_addr] = chr_wdata;
            chr_cnt++;
        end
    endtask

    task automatic do_rst();
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_strobes", 32'({prg_we, chr_we}), 0);
        chk("rst_flags", 32'({busy, done, error}), 0);
        chk("rst_addr", 32'({prg_addr, chr_addr}), 0);
        chk("rst_hdr", {prg_banks, chr_banks, mapper, 7'd0, mirror_v}, 0);
        rst = 1'b0;
        k = 0;
        last_k = 0;
        last_acc = 1'b0;
        prg_cnt = 0;
        chr_cnt = 0;
    endtask

    task automatic run_image(input int gap);
        int n = 0;
        int bad = 0;
        while (k < end_k && n < end_k * 3 + 100) begin
            cyc($urandom_range(0, 99) >= gap);
            n++;
        end
        chk("load_complete", k, end_k);
        repeat (4) cyc(1'b1);
        chk("hdr_prg_banks", 32'(prg_banks), 32'(e_prg));
        chk("hdr_chr_banks", 32'(chr_banks), 32'(e_chr));
        chk("hdr_mapper", 32'(mapper), 32'(e_map));
        chk("hdr_mirror_v", 32'(mirror_v), 32'(e_mir));
        for (int i = 0; i < p_len; i++) if (prg_mem[i] !== img[16 + t_len + i]) bad++;
        for (int i = 0; i < c_len; i++) if (chr_mem[i] !== img[16 + t_len + p_len + i]) bad++;
        chk("mem_bytes_wrong", bad, 0);
        chk("prg_writes", prg_cnt, p_len);
        chk("chr_writes", chr_cnt, c_len);
    endtask

    initial begin
        @(negedge clk);
        build(8'h01, 8'h01, 8'h01, 8'h00, 8'h53);
        do_rst();
        repeat (116) cyc(1'b1);
        chk("mid_prg_writes", prg_cnt, 100);
        do_rst();
        run_image(0);
        build(8'h01, 8'h01, 8'h01, 8'h00, 8'h54);
        do_rst();
        run_image(0);
        build(8'h02, 8'h00, 8'h04, 8'h00, 8'h53);
        do_rst();
        run_image(0);
        build(8'h01, 8'h01, 8'h10, 8'h20, 8'h53);
        do_rst();
        run_image(10);
        build(8'h03, 8'h01, 8'h00, 8'h00, 8'h53);
        do_rst();
        run_image(20);
        build(8'h00, 8'h01, 8'h01, 8'h00, 8'h53);
        do_rst();
        run_image(0);
        build(8'h01, 8'h02, 8'hF1, 8'hB0, 8'h53);
        do_rst();
        run_image(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
